// File: rtl/mult_pkg.sv
// Shared helpers for the multiplier family: half-width derivation and
// signed-magnitude conversion of operands up to MAX_W bits.
package mult_pkg;

  localparam int MAX_W = 64;

  function automatic int half_width(input int w);
    return w / 2;
  endfunction

  // x holds a w-bit value zero-extended to MAX_W bits
  function automatic logic sign_of(input logic [MAX_W-1:0] x, input int w);
    return x[6'(w - 1)];
  endfunction

  function automatic logic [MAX_W-1:0] abs_of(input logic [MAX_W-1:0] x, input int w);
    return x[6'(w - 1)] ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/pp_mult.sv
// Combinational H x H -> 2H unsigned partial-product multiplier.
module pp_mult #(
  parameter int H = 8
) (
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-1:0] p_o
);

  assign p_o = (2*H)'(a_i) * (2*H)'(b_i);

endmodule

// File: rtl/pipelined_mult.sv
// Three-stage signed/unsigned multiplier: sign-magnitude capture, four
// half-width partial products, then recombination with conditional negate.
module pipelined_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H  = half_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  // Handshake: a transfer happens on any edge where valid && ready. The whole
  // pipe moves together on adv; a stalled full output blocks the input.
  logic adv;

  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic             neg1_q, neg1_d, neg2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [WIDTH-1:0] ll_q, ll_d, hl_q, hl_d, lh_q, lh_d, hh_q, hh_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH:0]   mid;
  logic [PW-1:0]    sum;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    a1_d   = in_a;
    b1_d   = in_b;
    neg1_d = 1'b0;
    if (in_signed) begin
      a1_d   = WIDTH'(abs_of(MAX_W'(in_a), WIDTH));
      b1_d   = WIDTH'(abs_of(MAX_W'(in_b), WIDTH));
      neg1_d = sign_of(MAX_W'(in_a), WIDTH) ^ sign_of(MAX_W'(in_b), WIDTH);
    end
  end

  pp_mult #(.H(H)) u_pp_ll (.a_i(a1_q[H-1:0]),     .b_i(b1_q[H-1:0]),     .p_o(ll_d));
  pp_mult #(.H(H)) u_pp_hl (.a_i(a1_q[WIDTH-1:H]), .b_i(b1_q[H-1:0]),     .p_o(hl_d));
  pp_mult #(.H(H)) u_pp_lh (.a_i(a1_q[H-1:0]),     .b_i(b1_q[WIDTH-1:H]), .p_o(lh_d));
  pp_mult #(.H(H)) u_pp_hh (.a_i(a1_q[WIDTH-1:H]), .b_i(b1_q[WIDTH-1:H]), .p_o(hh_d));

  // Middle terms summed one bit wider so their carry survives the shift
  always_comb begin
    mid = {1'b0, hl_q} + {1'b0, lh_q};
    sum = PW'(ll_q) + (PW'(mid) << H) + (PW'(hh_q) << WIDTH);
    p_d = neg2_q ? (~sum + PW'(1)) : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      ll_q   <= '0;
      hl_q   <= '0;
      lh_q   <= '0;
      hh_q   <= '0;
      p_q    <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      neg1_q <= neg1_d;
      tag1_q <= in_tag;
      v2_q   <= v1_q;
      ll_q   <= ll_d;
      hl_q   <= hl_d;
      lh_q   <= lh_d;
      hh_q   <= hh_d;
      neg2_q <= neg1_q;
      tag2_q <= tag1_q;
      v3_q   <= v2_q;
      p_q    <= p_d;
      tag3_q <= tag2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_pipelined_mult.sv
// Bench for pipelined_mult: directed corners, stream, backpressure and reset
// on a 16-bit instance; random streams on 16-, 8- and 32-bit instances.
module tb_pipelined_mult;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int PW = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_signed;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_p;
  logic [TW-1:0] out_tag;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int out_cnt = 0;
  bit rand_ready = 1'b0;
  logic [TW+PW-1:0] exp_q[$];

  pipelined_mult #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: true integer product of the operands, reduced mod 2^(2w)
  function automatic logic [63:0] ref_mult(input logic [63:0] a, input logic [63:0] b,
                                           input logic s, input int w);
    logic [63:0] ext   = ~((64'd1 << w) - 64'd1);
    logic [63:0] pmask = (2 * w >= 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    if (s && a[w-1]) a = a | ext;
    if (s && b[w-1]) b = b | ext;
    return (a * b) & pmask;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [TW-1:0] tag);
    int t = 0;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      t++;
      if (t > 100) begin
        check("send_timeout", 64'(t), 64'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    exp_q.push_back({tag, PW'(ref_mult(64'(a), 64'(b), s, W))});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] tag, input logic [PW-1:0] expp);
    int k = 0;
    send(a, b, s, tag);
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    check($sformatf("%s_lat", name), 64'(k), 64'd3);
    check($sformatf("%s_p", name), 64'(out_p), 64'(expp));
    check($sformatf("%s_tag", name), 64'(out_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [TW+PW-1:0] e;
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_p), 64'd0);
        if (out_p == '0) check("unexpected_output_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_p", 64'(out_p), 64'(e[PW-1:0]));
        check("out_tag", 64'(out_tag), 64'(e[TW+PW-1:PW]));
      end
    end
  end

  // ---------------- random-only instances at WIDTH 8 and 32 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int GW = (g == 0) ? 8 : 32;
    localparam int GP = 2 * GW;
    logic          r_rst, r_in_valid, r_in_ready, r_signed, r_out_valid, r_out_ready;
    logic [GW-1:0] r_a, r_b;
    logic [TW-1:0] r_tag, r_out_tag;
    logic [GP-1:0] r_p;
    logic [TW+GP-1:0] q[$];
    bit done = 1'b0;

    pipelined_mult #(.WIDTH(GW), .TAG_W(TW)) u_dut (
      .clk(clk), .rst(r_rst),
      .in_valid(r_in_valid), .in_ready(r_in_ready),
      .in_a(r_a), .in_b(r_b), .in_signed(r_signed), .in_tag(r_tag),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .out_p(r_p), .out_tag(r_out_tag)
    );

    initial begin
      int t = 0;
      bit pend = 1'b0;
      r_rst = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b1;
      r_a = '0; r_b = '0; r_signed = 1'b0; r_tag = '0;
      repeat (3) @(posedge clk);
      #1 r_rst = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        r_out_ready = ($urandom_range(0, 3) != 0);
        if (!pend) begin
          r_in_valid = ($urandom_range(0, 4) != 0);
          r_a = GW'($urandom);
          r_b = GW'($urandom);
          r_signed = 1'($urandom_range(0, 1));
          r_tag = TW'($urandom);
        end
        @(negedge clk);
        pend = r_in_valid && !r_in_ready;
        if (r_in_valid && r_in_ready)
          q.push_back({r_tag, GP'(ref_mult(64'(r_a), 64'(r_b), r_signed, GW))});
        @(posedge clk); #1;
      end
      r_in_valid = 1'b0;
      r_out_ready = 1'b1;
      while (q.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      check((GW == 8) ? "w8_drain" : "w32_drain", 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!r_rst && r_out_valid && r_out_ready) begin
        logic [TW+GP-1:0] e;
        if (q.size() == 0) begin
          check((GW == 8) ? "w8_unexpected" : "w32_unexpected", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check((GW == 8) ? "w8_p" : "w32_p", 64'(r_p), 64'(e[GP-1:0]));
          check((GW == 8) ? "w8_tag" : "w32_tag", 64'(r_out_tag), 64'(e[TW+GP-1:GP]));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [PW-1:0] snap_p;
    logic [TW-1:0] snap_tag;
    int            base_cnt;
    int            t;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed products with latency measured from the accept edge
    run_one("u_ffff",   16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hFFFE0001);
    run_one("s_m1m1",   16'hFFFF, 16'hFFFF, 1'b1, 4'd4, 32'h00000001);
    run_one("s_minmin", 16'h8000, 16'h8000, 1'b1, 4'd5, 32'h40000000);
    run_one("s_min_1",  16'h8000, 16'h0001, 1'b1, 4'd6, 32'hFFFF8000);
    run_one("s_max_min",16'h7FFF, 16'h8000, 1'b1, 4'd7, 32'hC0008000);

    // Mixed-mode back-to-back stream
    stall_cnt = 0;
    base_cnt = out_cnt;
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom), 1'(i % 2), TW'(i));
    check("stream_stalls", 64'(stall_cnt), 64'd0);
    drain("stream_drain");
    check("stream_count", 64'(out_cnt - base_cnt), 64'd8);

    // Backpressure on a full pipe
    out_ready = 1'b0;
    base_cnt = out_cnt;
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), TW'(i + 9));
    @(negedge clk);
    snap_p = out_p;
    snap_tag = out_tag;
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_p", 64'(out_p), 64'(snap_p));
      check("bp_hold_tag", 64'(out_tag), 64'(snap_tag));
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_count", 64'(out_cnt - base_cnt), 64'd3);

    // Reset with two transactions in flight
    base_cnt = out_cnt;
    send(16'h1234, 16'h5678, 1'b0, 4'hA);
    send(16'h9ABC, 16'hDEF0, 1'b1, 4'hB);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_flight_out_valid", 64'(out_valid), 64'd0);
      check("rst_flight_in_ready", 64'(in_ready), 64'd1);
    end
    check("rst_flight_count", 64'(out_cnt - base_cnt), 64'd0);
    @(posedge clk); #1;

    // Random operands, modes and output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), TW'($urandom));
      else begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    t = 0;
    while (!(g_rnd[0].done && g_rnd[1].done) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    check("wide_narrow_done", 64'(g_rnd[0].done && g_rnd[1].done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_mult.md
# pipelined_mult

Parametrised, 3-stage pipelined multiplier with valid/ready handshake on both sides, per-transaction signed/unsigned mode and a pass-through tag. Splits each operand into high and low halves, forms four registered half-width partial products and sums them with a conditional negate. Replaces the combinational multiplier chain wherever a product feeds clocked datapath logic and must meet timing at full clock rate.

## Interface
- WIDTH, 16: operand width; even, ≥4. Product is 2·WIDTH bits.
- TAG_W, 4: width of the side-band tag carried alongside each product; ≥1.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- in_signed  in  1  1: two's-complement operands and product; 0: unsigned
- in_tag  in  TAG_W  user tag, returned unchanged with the product
- out_valid  out  1  product present
- out_ready  in  1  consumer accepts this cycle
- out_p  out  2·WIDTH  product
- out_tag  out  TAG_W  tag of that product

## Operation
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Three stages, each holding a valid bit. The pipeline advances as a whole on adv = !v3 || out_ready. in_ready = adv.
- S1 (on accept): in signed mode, register |a| and |b| as WIDTH-bit unsigned values and neg = sign(a) XOR sign(b). In unsigned mode, register the raw operands with neg = 0. Register the tag. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
- S2: split each operand at H = WIDTH/2 into hi and lo halves. Register the four H×H products: ll, hl, lh, hh, each WIDTH bits. Carry neg and tag forward.
- S3: sum = ll + ((hl + lh) << H) + (hh << WIDTH), computed in 2·WIDTH bits. The middle sum is computed at WIDTH+1 bits with no carry lost. Register out_p = neg ? −sum : sum, modulo 2^(2·WIDTH).
- When adv = 0, every stage holds its data and valid bit. The output holds stable (out_p, out_tag) while out_valid && !out_ready.
- Bubbles propagate: a stage with valid = 0 still shifts when adv = 1.
- in_signed applies per transaction. Mixed-mode back-to-back inputs are legal.

## Timing
- Reset: v1 = v2 = v3 = 0, so out_valid = 0. out_p = 0 and out_tag = 0. in_ready = 1 in the cycle after reset deasserts and while rst is held.
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N+2, which is the 3rd register. This assumes no stall.
- Throughput: one product per cycle while out_ready = 1.
- in_ready is combinational from out_ready and v3 (one gate). There is no combinational path from in_* to out_*.
- Simultaneous output handshake and input accept in a full pipeline is legal. Both complete in the same cycle.
- Reset mid-operation discards all in-flight transactions. No output valid is produced for them.
- If rst and in_valid are asserted together, the input is not accepted.

## Structure
- A shared package mult_pkg holds the signed-magnitude helper function (abs/sign of a WIDTH-bit value) and the localparam H = WIDTH/2 derivation rule. The package is reused by later multiplier variants.
- One natural sub-module: pp_mult, a combinational H×H → 2H unsigned multiplier. It is instantiated four times in S2.
- Stage registers and valid bits live in the top module. There is no FSM beyond the valid/stall logic.

## Test plan
All cases use WIDTH = 16, TAG_W = 4.
- Unsigned: a = 0xFFFF, b = 0xFFFF, tag = 3, out_ready held 1 → out_p = 0xFFFE0001, tag 3, out_valid exactly 3 cycles after accept.
- Signed corners:
  - −1 × −1 → 0x00000001
  - 0x8000 × 0x8000 → 0x40000000
  - 0x8000 × 0x0001 → 0xFFFF8000
  - 0x7FFF × 0x8000 → 0xC0008000
- Mixed stream: 8 back-to-back inputs alternating in_signed, with tags 0–7. Require 8 consecutive outputs in order with correct tags, and in_ready never low.
- Backpressure: fill the pipeline, then drop out_ready for 5 cycles. Require out_p/out_tag stable, in_ready = 0, and no loss or duplication after release. Order is preserved.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle at cycle +1. Require out_valid = 0 for the following 4 cycles and in_ready = 1.
- Random: 10k random operands, modes and out_ready patterns, checked against a 2·WIDTH reference model. Repeat with WIDTH = 8 and WIDTH = 32.
